// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte using the open-drain
// request-to-send sequence. Lines are driven only through active-high pull-low enables.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iSend,
   input  logic [7:0] iData,
   input  logic       iPS2_CLK,
   input  logic       iPS2_DATA,
   output logic       oPS2_CLK_OE,
   output logic       oPS2_DATA_OE,
   output logic       oBusy,
   output logic       oDone,
   output logic       oError
);

   localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
   localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StShift,
      StAck,
      StWaitIdle
   } state_e;

   // Input conditioning
   logic [1:0]            clk_sync_q, clk_sync_d;
   logic [1:0]            data_sync_q, data_sync_d;
   logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
   logic                  filt_q, filt_d;
   logic                  filt_prev_q, filt_prev_d;
   logic                  fe;

   // Transaction state
   state_e          state_q, state_d;
   logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
   logic [ToW-1:0]  to_cnt_q, to_cnt_d;
   logic [3:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      data_q, data_d;
   logic            parity_q, parity_d;
   logic            clk_oe_q, clk_oe_d;
   logic            data_oe_q, data_oe_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic            active;

   // Idle bus is high, so conditioning resets to ones to avoid a spurious edge.
   always_comb begin
      clk_sync_d  = {clk_sync_q[0], iPS2_CLK};
      data_sync_d = {data_sync_q[0], iPS2_DATA};
      filt_sr_d   = {filt_sr_q[FILTER_LEN-2:0], clk_sync_q[1]};
      filt_prev_d = filt_q;
      filt_d      = filt_q;
      if (&filt_sr_q) begin
         filt_d = 1'b1;
      end else if (~|filt_sr_q) begin
         filt_d = 1'b0;
      end
   end

   assign fe = filt_prev_q & ~filt_q;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         filt_sr_q   <= '1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         filt_sr_q   <= filt_sr_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_prev_d;
      end
   end

   assign active = (state_q == StReq) || (state_q == StShift) ||
                   (state_q == StAck) || (state_q == StWaitIdle);

   always_comb begin
      state_d   = state_q;
      inh_cnt_d = '0;
      to_cnt_d  = '0;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      parity_d  = parity_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      error_d   = 1'b0;

      case (state_q)
         StIdle: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            bit_idx_d = '0;
            // A request coinciding with the completion pulse is dropped.
            if (iSend && !done_q && !error_q) begin
               data_d   = iData;
               parity_d = ~^iData;
               clk_oe_d = 1'b1;
               state_d  = StInhibit;
            end
         end
         StInhibit: begin
            clk_oe_d = 1'b1;
            if (inh_cnt_q == InhLast) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               state_d   = StReq;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end
         StReq: begin
            to_cnt_d = to_cnt_q + 1'b1;
            // The first device edge after the start bit presents data bit 0.
            if (fe) begin
               data_oe_d = ~data_q[0];
               bit_idx_d = 4'd1;
               state_d   = StShift;
            end
         end
         StShift: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (fe) begin
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q < 4'd8) begin
                  data_oe_d = ~data_q[bit_idx_q[2:0]];
               end else if (bit_idx_q == 4'd8) begin
                  data_oe_d = ~parity_q;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = StAck;
               end
            end
         end
         StAck: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (fe) begin
               if (!data_sync_q[1]) begin
                  state_d = StWaitIdle;
               end else begin
                  error_d = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StWaitIdle: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (filt_q && data_sync_q[1]) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = StIdle;
         end
      endcase

      if (active && (to_cnt_q == ToLast)) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         done_d    = 1'b0;
         error_d   = 1'b1;
         to_cnt_d  = '0;
         state_d   = StIdle;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= StIdle;
         inh_cnt_q <= '0;
         to_cnt_q  <= '0;
         bit_idx_q <= '0;
         data_q    <= '0;
         parity_q  <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         inh_cnt_q <= inh_cnt_d;
         to_cnt_q  <= to_cnt_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         parity_q  <= parity_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign oPS2_CLK_OE  = clk_oe_q;
   assign oPS2_DATA_OE = data_oe_q;
   assign oBusy        = (state_q != StIdle);
   assign oDone        = done_q;
   assign oError       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out,
// captures data/parity/stop and optionally acknowledges.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int unsigned Inh = 20;
   localparam int unsigned To  = 4000;
   localparam int unsigned Flt = 4;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       iSend;
   logic [7:0] iData;
   logic       oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oDone, oError;
   logic       dev_clk, dev_data;
   logic       ps2_clk, ps2_data;

   assign ps2_clk  = dev_clk & ~oPS2_CLK_OE;
   assign ps2_data = dev_data & ~oPS2_DATA_OE;

   ps2_host_tx #(
      .INHIBIT_CYCLES (Inh),
      .TIMEOUT_CYCLES (To),
      .FILTER_LEN     (Flt)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .iSend        (iSend),
      .iData        (iData),
      .iPS2_CLK     (ps2_clk),
      .iPS2_DATA    (ps2_data),
      .oPS2_CLK_OE  (oPS2_CLK_OE),
      .oPS2_DATA_OE (oPS2_DATA_OE),
      .oBusy        (oBusy),
      .oDone        (oDone),
      .oError       (oError)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int done_cyc = 0, err_cyc = 0, busy_bad = 0, both_bad = 0, clk_oe_cyc = 0;
   int req_cyc = -1, err_at = -1, oe_at_req = -1;
   logic dprev = 1'b0;

   always @(posedge Clock) cyc <= cyc + 1;

   // Pulse and timing monitor, sampled away from the active edge.
   always @(negedge Clock) begin
      if (oDone) done_cyc <= done_cyc + 1;
      if (oError) err_cyc <= err_cyc + 1;
      if ((oDone || oError) && oBusy) busy_bad <= busy_bad + 1;
      if (oDone && oError) both_bad <= both_bad + 1;
      if (oPS2_CLK_OE) clk_oe_cyc <= clk_oe_cyc + 1;
      if (oError && err_at < 0) err_at <= cyc;
      if (oPS2_DATA_OE && !dprev && req_cyc < 0) begin
         req_cyc   <= cyc;
         oe_at_req <= clk_oe_cyc;
      end
      dprev <= oPS2_DATA_OE;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic clr_mon();
      done_cyc = 0; err_cyc = 0; busy_bad = 0; both_bad = 0; clk_oe_cyc = 0;
      req_cyc = -1; err_at = -1; oe_at_req = -1;
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge Clock);
      #1;
      iSend = 1'b1;
      iData = b;
      @(posedge Clock);
      #1;
      iSend = 1'b0;
   endtask

   task automatic wait_end();
      for (int i = 0; i < 300; i++) begin
         if (done_cyc + err_cyc > 0) break;
         wait_cyc(1);
      end
      wait_cyc(3);
   endtask

   // Device model: 100-cycle clock, samples data on each rising edge.
   task automatic dev_xfer(input bit do_ack, input bit glitch, input int abort_fe,
                           output logic [7:0] cap, output logic par, output logic stp,
                           output logic start_ok, output bit ok);
      int g;
      ok = 1'b0; cap = '0; par = 1'b0; stp = 1'b0; start_ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (ps2_clk === 1'b1 && ps2_data === 1'b0) break;
         wait_cyc(1);
      end
      if (!(ps2_clk === 1'b1 && ps2_data === 1'b0)) return;
      wait_cyc(10);
      start_ok = (ps2_data === 1'b0);
      for (int fe = 1; fe <= 11; fe++) begin
         dev_clk = 1'b0;
         if (fe == 11 && do_ack) dev_data = 1'b0;
         if (fe == abort_fe) begin
            ok = 1'b1;
            return;
         end
         wait_cyc(50);
         dev_clk = 1'b1;
         if (fe <= 8) cap[fe-1] = ps2_data;
         else if (fe == 9) par = ps2_data;
         else if (fe == 10) stp = ps2_data;
         else dev_data = 1'b1;
         if (glitch) begin
            g = (fe % 3) + 1;
            wait_cyc(15);
            dev_clk = 1'b0;
            wait_cyc(g);
            dev_clk = 1'b1;
            wait_cyc(35 - g);
         end else begin
            wait_cyc(50);
         end
      end
      ok = 1'b1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; iSend = 1'b0; iData = '0; dev_clk = 1'b1; dev_data = 1'b1;
      wait_cyc(3);
      n_checks++; if (oPS2_CLK_OE !== 1'b0) begin n_errors++; $display("FAIL rst_clk_oe: got %b expected 0", oPS2_CLK_OE); end
      n_checks++; if (oPS2_DATA_OE !== 1'b0) begin n_errors++; $display("FAIL rst_data_oe: got %b expected 0", oPS2_DATA_OE); end
      n_checks++; if (oBusy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", oBusy); end
      n_checks++; if (oDone !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b expected 0", oDone); end
      n_checks++; if (oError !== 1'b0) begin n_errors++; $display("FAIL rst_error: got %b expected 0", oError); end
      Reset = 1'b0;
      wait_cyc(10);
      n_checks++; if (oBusy !== 1'b0) begin n_errors++; $display("FAIL post_rst_busy: got %b expected 0", oBusy); end
   endtask

   task automatic test_send_ed();
      logic [7:0] cap; logic par, stp, st; bit ok;
      clr_mon();
      send(8'hED);
      n_checks++; if (oBusy !== 1'b1) begin n_errors++; $display("FAIL ed_busy: got %b expected 1", oBusy); end
      dev_xfer(1'b1, 1'b0, 0, cap, par, stp, st, ok);
      wait_end();
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL ed_req: got %b expected 1", ok); end
      n_checks++; if (oe_at_req !== 20) begin n_errors++; $display("FAIL ed_inhibit: got %0d cycles expected 20", oe_at_req); end
      n_checks++; if (st !== 1'b1) begin n_errors++; $display("FAIL ed_start: got %b expected 1", st); end
      n_checks++; if (cap !== 8'hED) begin n_errors++; $display("FAIL ed_byte: got %h expected ed", cap); end
      n_checks++; if (par !== 1'b1) begin n_errors++; $display("FAIL ed_parity: got %b expected 1", par); end
      n_checks++; if (stp !== 1'b1) begin n_errors++; $display("FAIL ed_stop: got %b expected 1", stp); end
      n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL ed_done: got %0d cycles expected 1", done_cyc); end
      n_checks++; if (err_cyc !== 0) begin n_errors++; $display("FAIL ed_error: got %0d cycles expected 0", err_cyc); end
      n_checks++; if (busy_bad !== 0) begin n_errors++; $display("FAIL ed_busy_at_pulse: got %0d expected 0", busy_bad); end
      n_checks++; if (oBusy !== 1'b0) begin n_errors++; $display("FAIL ed_busy_end: got %b expected 0", oBusy); end
   endtask

   task automatic test_send_01_00();
      logic [7:0] bytes [2] = '{8'h01, 8'h00};
      logic       pexp [2]  = '{1'b0, 1'b1};
      logic [7:0] cap; logic par, stp, st; bit ok;
      for (int i = 0; i < 2; i++) begin
         clr_mon();
         send(bytes[i]);
         dev_xfer(1'b1, 1'b0, 0, cap, par, stp, st, ok);
         wait_end();
         n_checks++; if (cap !== bytes[i]) begin n_errors++; $display("FAIL b%0d_byte: got %h expected %h", i, cap, bytes[i]); end
         n_checks++; if (par !== pexp[i]) begin n_errors++; $display("FAIL b%0d_parity: got %b expected %b", i, par, pexp[i]); end
         n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL b%0d_done: got %0d expected 1", i, done_cyc); end
         n_checks++; if (both_bad !== 0) begin n_errors++; $display("FAIL b%0d_both: got %0d expected 0", i, both_bad); end
      end
   endtask

   task automatic test_no_ack();
      logic [7:0] cap; logic par, stp, st; bit ok;
      clr_mon();
      send(8'h55);
      dev_xfer(1'b0, 1'b0, 0, cap, par, stp, st, ok);
      wait_end();
      n_checks++; if (err_cyc !== 1) begin n_errors++; $display("FAIL nack_error: got %0d cycles expected 1", err_cyc); end
      n_checks++; if (done_cyc !== 0) begin n_errors++; $display("FAIL nack_done: got %0d expected 0", done_cyc); end
      n_checks++; if ({oPS2_CLK_OE, oPS2_DATA_OE, oBusy} !== 3'b000) begin n_errors++; $display("FAIL nack_idle: got %b expected 000", {oPS2_CLK_OE, oPS2_DATA_OE, oBusy}); end
      clr_mon();
      send(8'hFF);
      dev_xfer(1'b1, 1'b0, 0, cap, par, stp, st, ok);
      wait_end();
      n_checks++; if (cap !== 8'hFF) begin n_errors++; $display("FAIL ff_byte: got %h expected ff", cap); end
      n_checks++; if (par !== 1'b1) begin n_errors++; $display("FAIL ff_parity: got %b expected 1", par); end
      n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL ff_done: got %0d expected 1", done_cyc); end
   endtask

   task automatic test_timeout();
      clr_mon();
      send(8'hA5);
      for (int i = 0; i < 4300; i++) begin
         if (err_cyc > 0) break;
         wait_cyc(1);
      end
      wait_cyc(3);
      n_checks++; if (req_cyc < 0) begin n_errors++; $display("FAIL to_req: got %0d expected request", req_cyc); end
      n_checks++; if (err_at - req_cyc !== 4000) begin n_errors++; $display("FAIL to_latency: got %0d expected 4000", err_at - req_cyc); end
      n_checks++; if (err_cyc !== 1) begin n_errors++; $display("FAIL to_error: got %0d cycles expected 1", err_cyc); end
      n_checks++; if ({oPS2_CLK_OE, oPS2_DATA_OE, oBusy} !== 3'b000) begin n_errors++; $display("FAIL to_release: got %b expected 000", {oPS2_CLK_OE, oPS2_DATA_OE, oBusy}); end
   endtask

   task automatic test_glitch_and_resend();
      logic [7:0] cap; logic par, stp, st; bit ok;
      clr_mon();
      send(8'hED);
      wait_cyc(5);
      send(8'h12);
      dev_xfer(1'b1, 1'b1, 0, cap, par, stp, st, ok);
      wait_end();
      n_checks++; if (cap !== 8'hED) begin n_errors++; $display("FAIL gl_byte: got %h expected ed", cap); end
      n_checks++; if (par !== 1'b1) begin n_errors++; $display("FAIL gl_parity: got %b expected 1", par); end
      n_checks++; if (stp !== 1'b1) begin n_errors++; $display("FAIL gl_stop: got %b expected 1", stp); end
      n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL gl_done: got %0d expected 1", done_cyc); end
      n_checks++; if (err_cyc !== 0) begin n_errors++; $display("FAIL gl_error: got %0d expected 0", err_cyc); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] cap; logic par, stp, st; bit ok;
      clr_mon();
      send(8'h00);
      dev_xfer(1'b1, 1'b0, 5, cap, par, stp, st, ok);
      n_checks++; if (oPS2_DATA_OE !== 1'b1) begin n_errors++; $display("FAIL mid_pre_oe: got %b expected 1", oPS2_DATA_OE); end
      #2;
      Reset = 1'b1;
      #1;
      n_checks++; if ({oPS2_CLK_OE, oPS2_DATA_OE} !== 2'b00) begin n_errors++; $display("FAIL mid_async_oe: got %b expected 00", {oPS2_CLK_OE, oPS2_DATA_OE}); end
      n_checks++; if ({oBusy, oDone, oError} !== 3'b000) begin n_errors++; $display("FAIL mid_outputs: got %b expected 000", {oBusy, oDone, oError}); end
      wait_cyc(3);
      Reset = 1'b0;
      dev_clk = 1'b1;
      dev_data = 1'b1;
      wait_cyc(20);
      clr_mon();
      send(8'hF4);
      dev_xfer(1'b1, 1'b0, 0, cap, par, stp, st, ok);
      wait_end();
      n_checks++; if (cap !== 8'hF4) begin n_errors++; $display("FAIL f4_byte: got %h expected f4", cap); end
      n_checks++; if (par !== 1'b0) begin n_errors++; $display("FAIL f4_parity: got %b expected 0", par); end
      n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL f4_done: got %0d expected 1", done_cyc); end
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_send_01_00();
      test_no_ack();
      test_timeout();
      test_glitch_and_resend();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
